sample_scheduler: RTL and testbench
===================================

Name: sample_scheduler

Overview:
Synthesizable scheduler that sequences stimulus reading and result writing against the DUT clock. It replaces free-running reading/writing clocks with phase-locked, single-cycle strobes on one clock domain. Each read strobe is followed by exactly one write strobe a programmable number of cycles later. It sits between clk_driver and the ReadDriver/WriteDriver environment, with start/stop/done control for bounded or unbounded runs.

Parameters:
DIV_WIDTH, 16, width of the sample-period divisor
LAT_WIDTH, 8, width of the read-to-write latency
CNT_WIDTH, 32, width of the sample counters and num_samples

Ports:
clk  in  1  DUT clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a run; sampled only in IDLE
stop  in  1  request early termination; sampled only in RUN
divisor  in  DIV_WIDTH  sample period in clk cycles, latched at start
latency  in  LAT_WIDTH  read-to-write delay in cycles, latched at start
num_samples  in  CNT_WIDTH  reads per run, latched at start; 0 = unbounded
read_stb  out  1  one-cycle strobe: fetch the next stimulus sample
write_stb  out  1  one-cycle strobe: log the result for the matching read
busy  out  1  run in progress (RUN or DRAIN)
done  out  1  one-cycle pulse when a run completes
cfg_error  out  1  one-cycle pulse when start is rejected
read_count  out  CNT_WIDTH  read strobes issued this run
write_count  out  CNT_WIDTH  write strobes issued this run

Behaviour:
- Reset (asynchronous, immediate, including mid-run): state IDLE; all outputs 0; counters, phase and latency timers cleared. No strobe is issued after reset deasserts until a new start.
- States:
  - IDLE: waits for start.
  - RUN: issues read strobes periodically.
  - DRAIN: no new reads; waits for the pending write.
  - DONE: one cycle, done=1, then returns to IDLE.
- IDLE start acceptance, start=1 at edge T:
  - If divisor==0, or latency>=divisor: cfg_error=1 in cycle T+1, remain IDLE, counters unchanged.
  - Otherwise: latch config, clear read_count and write_count, enter RUN. busy=1 from cycle T+1.
- Read strobes:
  - read_stb=1 in cycles T+1+k*divisor, for k=0,1,...
  - read_count increments in the same cycle read_stb is high (registered value visible next cycle).
  - divisor==1 gives read_stb continuously high, one sample per cycle.
- Write strobes:
  - write_stb=1 exactly latency cycles after each read_stb. latency==0 gives same-cycle read_stb and write_stb.
  - write_count increments per write_stb.
  - latency<divisor guarantees at most one write outstanding, so a single countdown timer suffices.
- RUN to DRAIN:
  - On the cycle issuing read number num_samples (num_samples!=0).
  - Or on stop=1 in RUN, with no further reads after that edge. If stop coincides with a read_stb cycle, that read is still issued and counted.
- DRAIN to DONE: on the cycle the final write_stb is issued, or immediately if no write is outstanding. In DONE: done=1, busy=0. Invariant at done: write_count==read_count.
- start while busy is ignored. stop outside RUN is ignored. In IDLE, start and stop together means start is accepted.
- num_samples==0: runs until stop. Counters wrap modulo 2^CNT_WIDTH.
- read_count and write_count hold their final values in IDLE until the next accepted start.
- All outputs are registered. No combinational input-to-output path.

Test Plan:
- Reset values: hold rst_n=0, toggle inputs -> all outputs 0. Assert rst_n=0 mid-RUN -> busy, read_stb, write_stb drop immediately; no strobes after release.
- Basic bounded run: divisor=4, latency=2, num_samples=3, start at T -> read_stb at T+1, T+5, T+9; write_stb at T+3, T+7, T+11; done at T+12; both counts=3.
- Back-to-back sampling: divisor=1, latency=0, num_samples=5 -> read_stb and write_stb high together for 5 consecutive cycles; done the next cycle.
- Config error: divisor=0 -> cfg_error pulse, busy stays 0. Then divisor=3, latency=3 -> cfg_error pulse. Then latency=2 -> accepted.
- Early stop, unbounded: divisor=8, latency=5, num_samples=0, stop asserted 2 cycles after the 4th read -> no 5th read; 4th write still issued; done; read_count=write_count=4.
- Ignored controls: start pulsed during RUN -> counts and timing unchanged. stop in IDLE -> no effect. start and stop together in IDLE -> run starts normally.

Source files
------------

// File: rtl/sample_scheduler.sv
// sample_scheduler: phase-locked read/write strobe sequencer.
// One read every divisor cycles, its write latency cycles later.
module sample_scheduler #(
  parameter int DIV_WIDTH = 16,
  parameter int LAT_WIDTH = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [LAT_WIDTH-1:0] latency,
  input  logic [CNT_WIDTH-1:0] num_samples,
  output logic                 read_stb,
  output logic                 write_stb,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_error,
  output logic [CNT_WIDTH-1:0] read_count,
  output logic [CNT_WIDTH-1:0] write_count
);

  localparam int CMP_W =
    (DIV_WIDTH > LAT_WIDTH) ? DIV_WIDTH : LAT_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_phase;
  logic [LAT_WIDTH-1:0] r_lat;
  logic [LAT_WIDTH-1:0] r_lat_tmr;
  logic [CNT_WIDTH-1:0] r_num;
  logic [CNT_WIDTH-1:0] r_issued;
  logic [CNT_WIDTH-1:0] r_read_count;
  logic [CNT_WIDTH-1:0] r_write_count;
  logic                 r_read_stb;
  logic                 r_write_stb;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_cfg_error;

  logic                 w_cfg_bad;
  logic [CNT_WIDTH-1:0] w_issued_nxt;
  logic                 w_last_read;

  assign w_cfg_bad = (divisor == '0) ||
    (CMP_W'(latency) >= CMP_W'(divisor));
  assign w_issued_nxt = r_issued + CNT_WIDTH'(1);
  assign w_last_read = (r_num != '0) &&
    (w_issued_nxt == r_num);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_div         <= '0;
      r_phase       <= '0;
      r_lat         <= '0;
      r_lat_tmr     <= '0;
      r_num         <= '0;
      r_issued      <= '0;
      r_read_count  <= '0;
      r_write_count <= '0;
      r_read_stb    <= 1'b0;
      r_write_stb   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_cfg_error   <= 1'b0;
    end else begin
      r_read_stb  <= 1'b0;
      r_write_stb <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_error <= 1'b0;
      if (r_read_stb)
        r_read_count <= r_read_count + CNT_WIDTH'(1);
      if (r_write_stb)
        r_write_count <= r_write_count + CNT_WIDTH'(1);
      // latency < divisor: at most one write pending
      if (r_lat_tmr != '0) begin
        r_lat_tmr <= r_lat_tmr - LAT_WIDTH'(1);
        if (r_lat_tmr == LAT_WIDTH'(1))
          r_write_stb <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (start && w_cfg_bad) begin
            r_cfg_error <= 1'b1;
          end else if (start) begin
            r_div         <= divisor;
            r_lat         <= latency;
            r_num         <= num_samples;
            r_read_count  <= '0;
            r_write_count <= '0;
            r_busy        <= 1'b1;
            r_read_stb    <= 1'b1;
            r_issued      <= CNT_WIDTH'(1);
            r_phase       <= divisor - DIV_WIDTH'(1);
            if (latency == '0) r_write_stb <= 1'b1;
            else               r_lat_tmr   <= latency;
            r_state <= (num_samples == CNT_WIDTH'(1)) ?
              S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            r_state <= S_DRAIN;
          end else if (r_phase != '0) begin
            r_phase <= r_phase - DIV_WIDTH'(1);
          end else begin
            r_read_stb <= 1'b1;
            r_issued   <= w_issued_nxt;
            r_phase    <= r_div - DIV_WIDTH'(1);
            if (r_lat == '0) r_write_stb <= 1'b1;
            else             r_lat_tmr   <= r_lat;
            if (w_last_read) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_lat_tmr == '0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign read_stb    = r_read_stb;
  assign write_stb   = r_write_stb;
  assign busy        = r_busy;
  assign done        = r_done;
  assign cfg_error   = r_cfg_error;
  assign read_count  = r_read_count;
  assign write_count = r_write_count;

endmodule

// File: tb/tb_sample_scheduler.sv
// tb_sample_scheduler: random and directed runs of sample_scheduler
// compared against a cycle-schedule model derived from the rules.
module tb_sample_scheduler;

  localparam int MAXC = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] divisor = '0;
  logic [7:0]  latency = '0;
  logic [31:0] num_samples = '0;
  logic        read_stb;
  logic        write_stb;
  logic        busy;
  logic        done;
  logic        cfg_error;
  logic [31:0] read_count;
  logic [31:0] write_count;

  int checks = 0;
  int passes = 0;

  logic [MAXC-1:0] obs_rd, obs_wr, obs_dn, obs_bz;
  logic [MAXC-1:0] exp_rd, exp_wr, exp_dn, exp_bz;
  logic [31:0]     obs_rc, obs_wc;
  int              exp_n;
  int              exp_done;

  sample_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .divisor     (divisor),
    .latency     (latency),
    .num_samples (num_samples),
    .read_stb    (read_stb),
    .write_stb   (write_stb),
    .busy        (busy),
    .done        (done),
    .cfg_error   (cfg_error),
    .read_count  (read_count),
    .write_count (write_count)
  );

  always #5 clk = ~clk;

  // Start sampled at the end of cycle 0; stop s sampled at end of cycle s.
  task automatic model(input int div, input int lat,
                       input int num, input int s);
    int  r;
    int  lastw;
    bit  eff;
    exp_rd = '0; exp_wr = '0; exp_dn = '0; exp_bz = '0;
    exp_n = 0;
    lastw = 0;
    for (int k = 0; k < MAXC; k++) begin
      r = 1 + k * div;
      if (num != 0 && k >= num) break;
      if (s > 0 && k >= 1 && k * div >= s) break;
      if (r + lat >= MAXC - 8) break;
      exp_rd[r] = 1'b1;
      exp_wr[r + lat] = 1'b1;
      exp_n++;
      lastw = r + lat;
    end
    eff = (s > 0) && (num == 0 || s <= (num - 1) * div);
    exp_done = lastw + 1;
    if (eff && s + 2 > exp_done) exp_done = s + 2;
    exp_dn[exp_done] = 1'b1;
    for (int c = 1; c < exp_done; c++) exp_bz[c] = 1'b1;
  endtask

  task automatic run(input int div, input int lat, input int num,
                     input int stop_cyc, input int spulse,
                     input bit stop_at_start, input int ncyc);
    obs_rd = '0; obs_wr = '0; obs_dn = '0; obs_bz = '0;
    obs_rc = '1; obs_wc = '1;
    @(posedge clk); #1;
    divisor = 16'(div);
    latency = 8'(lat);
    num_samples = 32'(num);
    start = 1'b1;
    stop = stop_at_start;
    for (int c = 1; c < ncyc; c++) begin
      @(posedge clk); #1;
      start = (c == spulse || c == spulse + 3) && spulse != 0;
      stop = (c == stop_cyc);
      obs_rd[c] = read_stb;
      obs_wr[c] = write_stb;
      obs_dn[c] = done;
      obs_bz[c] = busy;
      if (done) begin
        obs_rc = read_count;
        obs_wc = write_count;
      end
    end
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom);
      stop = 1'($urandom);
      divisor = 16'($urandom_range(1, 5));
      num_samples = 32'($urandom_range(0, 3));
      @(posedge clk); #1;
      checks++;
      if ({read_stb, write_stb, busy, done, cfg_error,
           read_count, write_count} !== '0)
        $display("FAIL reset_hold got rd=%b wr=%b busy=%b rc=%0d want 0",
                 read_stb, write_stb, busy, read_count);
      else passes++;
    end
    start = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({read_stb, write_stb, busy} !== 3'b000)
      $display("FAIL reset_release got rd=%b wr=%b busy=%b want 000",
               read_stb, write_stb, busy);
    else passes++;
  endtask

  task automatic test_basic();
    model(4, 2, 3, 0);
    run(4, 2, 3, 0, 0, 1'b0, exp_done + 4);
    checks++;
    if ({obs_rd, obs_wr} !== {exp_rd, exp_wr})
      $display("FAIL basic_strobes got rd=%h wr=%h want rd=%h wr=%h",
               obs_rd, obs_wr, exp_rd, exp_wr);
    else passes++;
    checks++;
    if ({obs_dn, obs_bz} !== {exp_dn, exp_bz})
      $display("FAIL basic_ctrl got dn=%h bz=%h want dn=%h bz=%h",
               obs_dn, obs_bz, exp_dn, exp_bz);
    else passes++;
    checks++;
    if (obs_dn[12] !== 1'b1 || obs_rc !== 32'd3 || obs_wc !== 32'd3)
      $display("FAIL basic_done got dn12=%b rc=%0d wc=%0d want 1 3 3",
               obs_dn[12], obs_rc, obs_wc);
    else passes++;
    checks++;
    if (read_count !== 32'd3 || write_count !== 32'd3)
      $display("FAIL basic_hold got rc=%0d wc=%0d want 3 3",
               read_count, write_count);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [4:0] rd5;
    logic [4:0] wr5;
    model(1, 0, 5, 0);
    run(1, 0, 5, 0, 0, 1'b0, exp_done + 4);
    rd5 = obs_rd[5:1];
    wr5 = obs_wr[5:1];
    checks++;
    if (rd5 !== 5'h1f || wr5 !== 5'h1f || obs_dn[6] !== 1'b1)
      $display("FAIL b2b_direct got rd=%b wr=%b dn6=%b want 11111 11111 1",
               rd5, wr5, obs_dn[6]);
    else passes++;
    checks++;
    if ({obs_rd, obs_wr, obs_dn, obs_bz} !==
        {exp_rd, exp_wr, exp_dn, exp_bz})
      $display("FAIL b2b_trace got rd=%h dn=%h want rd=%h dn=%h",
               obs_rd, obs_dn, exp_rd, exp_dn);
    else passes++;
    checks++;
    if (obs_rc !== 32'd5 || obs_wc !== 32'd5)
      $display("FAIL b2b_counts got rc=%0d wc=%0d want 5 5",
               obs_rc, obs_wc);
    else passes++;
  endtask

  task automatic test_cfg_error();
    logic [31:0] held;
    held = 32'(exp_n);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      divisor = (i == 0) ? 16'd0 : 16'd3;
      latency = (i == 0) ? 8'd0 : 8'd3;
      num_samples = 32'd2;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (cfg_error !== 1'b1 || busy !== 1'b0 || read_stb !== 1'b0)
        $display("FAIL cfg_err%0d got err=%b busy=%b rd=%b want 1 0 0",
                 i, cfg_error, busy, read_stb);
      else passes++;
      @(posedge clk); #1;
      checks++;
      if (cfg_error !== 1'b0 || busy !== 1'b0 || read_count !== held)
        $display("FAIL cfg_after%0d got err=%b busy=%b rc=%0d want 0 0 %0d",
                 i, cfg_error, busy, read_count, held);
      else passes++;
    end
    model(3, 2, 2, 0);
    run(3, 2, 2, 0, 0, 1'b0, exp_done + 4);
    checks++;
    if ({obs_rd, obs_wr, obs_dn, obs_bz} !==
        {exp_rd, exp_wr, exp_dn, exp_bz} ||
        obs_rc !== 32'(exp_n) || obs_wc !== 32'(exp_n))
      $display("FAIL cfg_accept got rd=%h wr=%h rc=%0d want rd=%h wr=%h rc=%0d",
               obs_rd, obs_wr, obs_rc, exp_rd, exp_wr, exp_n);
    else passes++;
  endtask

  task automatic test_early_stop();
    model(8, 5, 0, 27);
    run(8, 5, 0, 27, 0, 1'b0, exp_done + 4);
    checks++;
    if (obs_rd[33] !== 1'b0 || obs_wr[30] !== 1'b1)
      $display("FAIL stop_direct got rd33=%b wr30=%b want 0 1",
               obs_rd[33], obs_wr[30]);
    else passes++;
    checks++;
    if ({obs_rd, obs_wr, obs_dn, obs_bz} !==
        {exp_rd, exp_wr, exp_dn, exp_bz})
      $display("FAIL stop_trace got rd=%h wr=%h dn=%h want rd=%h wr=%h dn=%h",
               obs_rd, obs_wr, obs_dn, exp_rd, exp_wr, exp_dn);
    else passes++;
    checks++;
    if (obs_rc !== 32'd4 || obs_wc !== 32'd4)
      $display("FAIL stop_counts got rc=%0d wc=%0d want 4 4",
               obs_rc, obs_wc);
    else passes++;
  endtask

  task automatic test_ignored();
    logic [31:0] held;
    bit          seen;
    held = read_count;
    seen = 1'b0;
    stop = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      seen |= busy | read_stb | write_stb | done;
    end
    stop = 1'b0;
    checks++;
    if (seen || read_count !== held)
      $display("FAIL stop_idle got activity=%b rc=%0d want 0 %0d",
               seen, read_count, held);
    else passes++;
    model(4, 2, 3, 0);
    run(4, 2, 3, 0, 3, 1'b0, exp_done + 4);
    checks++;
    if ({obs_rd, obs_wr, obs_dn, obs_bz} !==
        {exp_rd, exp_wr, exp_dn, exp_bz} ||
        obs_rc !== 32'd3 || obs_wc !== 32'd3)
      $display("FAIL start_busy got rd=%h wr=%h rc=%0d want rd=%h wr=%h rc=3",
               obs_rd, obs_wr, obs_rc, exp_rd, exp_wr);
    else passes++;
    model(2, 1, 4, 0);
    run(2, 1, 4, 0, 0, 1'b1, exp_done + 4);
    checks++;
    if ({obs_rd, obs_wr, obs_dn, obs_bz} !==
        {exp_rd, exp_wr, exp_dn, exp_bz} ||
        obs_rc !== 32'd4 || obs_wc !== 32'd4)
      $display("FAIL start_stop got rd=%h wr=%h rc=%0d want rd=%h wr=%h rc=4",
               obs_rd, obs_wr, obs_rc, exp_rd, exp_wr);
    else passes++;
  endtask

  task automatic test_random();
    int div, lat, num, s;
    for (int i = 0; i < 12; i++) begin
      div = int'($urandom_range(1, 6));
      lat = int'($urandom_range(0, div - 1));
      if ($urandom_range(0, 2) == 0) num = 0;
      else num = int'($urandom_range(1, 5));
      if (num == 0) s = int'($urandom_range(1, 30));
      else if ($urandom_range(0, 1) == 1)
        s = int'($urandom_range(1, num * div));
      else s = 0;
      model(div, lat, num, s);
      run(div, lat, num, s, 0, 1'b0, exp_done + 4);
      checks++;
      if ({obs_rd, obs_wr} !== {exp_rd, exp_wr})
        $display("FAIL rand%0d_strobes d=%0d l=%0d n=%0d s=%0d got rd=%h wr=%h want rd=%h wr=%h",
                 i, div, lat, num, s, obs_rd, obs_wr, exp_rd, exp_wr);
      else passes++;
      checks++;
      if ({obs_dn, obs_bz} !== {exp_dn, exp_bz})
        $display("FAIL rand%0d_ctrl got dn=%h bz=%h want dn=%h bz=%h",
                 i, obs_dn, obs_bz, exp_dn, exp_bz);
      else passes++;
      checks++;
      if (obs_rc !== 32'(exp_n) || obs_wc !== 32'(exp_n))
        $display("FAIL rand%0d_counts got rc=%0d wc=%0d want %0d",
                 i, obs_rc, obs_wc, exp_n);
      else passes++;
    end
  endtask

  task automatic test_reset_midrun();
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    divisor = 16'd4;
    latency = 8'd2;
    num_samples = 32'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || read_count === 32'd0)
      $display("FAIL midrun_active got busy=%b rc=%0d want 1 nonzero",
               busy, read_count);
    else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, read_stb, write_stb, done, read_count, write_count} !== '0)
      $display("FAIL midrun_reset got busy=%b rd=%b wr=%b rc=%0d want 0",
               busy, read_stb, write_stb, read_count);
    else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      seen |= busy | read_stb | write_stb | done;
    end
    checks++;
    if (seen)
      $display("FAIL midrun_release got activity=1 want 0");
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cfg_error();
    test_back_to_back();
    test_early_stop();
    test_ignored();
    test_random();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
